serial_tx_buff: RTL and testbench
=================================

SERIAL_TX_BUFF -- requirements
Module: serial_tx_buff

Interface
REQ-001 Parameter NDATA, default 128: word width in bits; SHALL be >= 2.
REQ-002 Parameter NGAP, default 1: idle cycles with ena low after each word; SHALL be >= 1.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  NDATA  parallel word to transmit.
REQ-006 din_valid  input  1  din holds a word to send.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  1  serial data bit.
REQ-009 ena  output  1  dout carries a valid bit this cycle; drives the receive-side deserializer's ena.
REQ-010 done  output  1  one-cycle pulse at the end of each word's gap period.

Function
REQ-011 FSM states SHALL be exactly IDLE, SHIFT, GAP.
REQ-012 IDLE: din_ready=1, ena=0, dout=0.
REQ-013 Handshake: a word SHALL be accepted only on a rising edge with din_valid=1 and din_ready=1; din SHALL be captured into an internal NDATA-bit shift register on that edge.
REQ-014 On acceptance the FSM SHALL move IDLE->SHIFT; din_ready SHALL be 0 in SHIFT and GAP.
REQ-015 Latency: the first bit SHALL appear on dout with ena=1 in the cycle immediately after acceptance.
REQ-016 Bit order: MSB first; the k-th SHIFT cycle (k=0..NDATA-1) SHALL present din[NDATA-1-k].
REQ-017 ena SHALL be 1 for exactly NDATA consecutive cycles per word, and 1 in no other cycle.
REQ-018 A bit counter, width $clog2(NDATA), SHALL count SHIFT cycles; when it reaches NDATA-1, the FSM SHALL go SHIFT->GAP on the next edge and the counter SHALL wrap to 0.
REQ-019 GAP: ena=0, dout=0 for exactly NGAP cycles, counted by a gap counter; then GAP->IDLE.
REQ-020 done SHALL be 1 in the last GAP cycle only.
REQ-021 Minimum word period SHALL be NDATA+NGAP+1 cycles (accept, NDATA shift, NGAP gap); no back-to-back overlap.
REQ-022 din_valid and din changes during SHIFT/GAP SHALL be ignored; the transmitted word SHALL be unaffected.
REQ-023 din_valid held high continuously SHALL yield words separated by exactly one IDLE cycle.

Reset
REQ-024 While rst=1 on a rising edge: FSM->IDLE, both counters->0, shift register->0, dout=0, ena=0, done=0.
REQ-025 din_ready SHALL be 0 in any cycle where rst=1; it SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-SHIFT or mid-GAP SHALL abort the word immediately, without a done pulse; the word is not retransmitted.

Structure
REQ-027 State encoding (IDLE/SHIFT/GAP) and the counter-width function SHALL reside in the shared project package.
REQ-028 The parallel-load, MSB-first shift register SHALL be a separate sub-module, piso_reg (parameter NDATA; ports clk, rst, load, shift, din, dout), with rst as in REQ-004.
REQ-029 dout, ena, done and din_ready SHALL be driven from registers or decoded from the registered state only; no combinational path from din/din_valid to any output.

Verification (NDATA=8, NGAP=1 unless stated)
REQ-030 Reset, then din=8'hA5, din_valid pulsed 1 cycle -> next 8 cycles ena=1, dout=1,0,1,0,0,1,0,1; then 1 cycle ena=0, done=1; then din_ready=1.
REQ-031 din_valid held high with din=8'hFF then 8'h00 -> ena high 8 cycles, low 2 cycles (GAP+IDLE), high 8 cycles; dout all 1 then all 0.
REQ-032 din changed to 8'h3C during SHIFT of 8'hC3 -> serial stream is still C3, MSB first.
REQ-033 rst asserted at the 4th SHIFT cycle -> next cycle ena=0, dout=0, no done, din_ready=1 after rst drops; a new word 8'h81 transmits correctly.
REQ-034 NGAP=3, NDATA=128, random word -> ena high exactly 128 cycles, low 3 cycles, done on 3rd; loopback through the receive-side deserializer returns the same 128-bit word.

Source files
------------

// File: rtl/serial_tx_buff_pkg.sv
// Shared types and helpers for the serial transmit buffer.
package serial_tx_buff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter width for a count of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_buff_piso_reg.sv
// Parallel-load, MSB-first shift register; zeros fill from the LSB end.
module piso_reg #(
  parameter int NDATA = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [NDATA-1:0] din,
  output logic             dout
);

  logic [NDATA-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst)        sr_q <= '0;
    else if (load)  sr_q <= din;
    else if (shift) sr_q <= {sr_q[NDATA-2:0], 1'b0};
  end

  assign dout = sr_q[NDATA-1];

endmodule

// File: rtl/serial_tx_buff.sv
// Serialises one NDATA-bit word MSB first with an ena qualifier, then idles
// NGAP cycles and pulses done before accepting the next word.
module serial_tx_buff
  import serial_tx_buff_pkg::*;
#(
  parameter int NDATA = 128,
  parameter int NGAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NDATA-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             ena,
  output logic             done
);

  localparam int CNT_W = cnt_w(NDATA);
  localparam int GAP_W = cnt_w(NGAP);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NDATA - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(NGAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             load, shift_en, sr_msb;

  assign load = din_valid && (state_q == IDLE);

  piso_reg #(.NDATA(NDATA)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift_en),
    .din  (din),
    .dout (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: if (din_valid) state_d = SHIFT;
      SHIFT: begin
        // The bit on dout now is consumed; advance to the next one.
        shift_en = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = GAP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; rst masks ready in its own cycle.
  assign din_ready = (state_q == IDLE) && !rst;
  assign ena       = (state_q == SHIFT);
  assign dout      = ena && sr_msb;
  assign done      = (state_q == GAP) && (gap_cnt_q == LAST_GAP);

endmodule

// File: tb/tb_serial_tx_buff.sv
// Bench for serial_tx_buff: vector table, queue-based reference model with
// random stimulus, and a 128-bit / NGAP=3 loopback run.
module tb_serial_tx_buff;

  localparam int NG = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dv;
  logic [7:0] din;
  logic       rdy, ena, dout, done;

  serial_tx_buff #(.NDATA(8), .NGAP(NG)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv),
    .din_ready(rdy), .dout(dout), .ena(ena), .done(done)
  );

  logic         rst2, dv2;
  logic [127:0] din2;
  logic         rdy2, ena2, dout2, done2;

  serial_tx_buff #(.NDATA(128), .NGAP(3)) dut2 (
    .clk(clk), .rst(rst2), .din(din2), .din_valid(dv2),
    .din_ready(rdy2), .dout(dout2), .ena(ena2), .done(done2)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       rdy, ena, dout, done;
  } vec_t;
  vec_t tbl[12];

  // Reference model: each accepted word schedules its whole output stream.
  typedef struct packed { logic ena; logic dout; logic done; } ob_t;
  ob_t mq[$];

  task automatic mcyc(input logic r, input logic v, input logic [7:0] d, input string nm);
    ob_t  e;
    logic er;
    rst = r; dv = v; din = d;
    #1;
    e  = (mq.size() > 0) ? mq[0] : '0;
    er = (mq.size() == 0) && !r;
    chk({nm, " ready"}, rdy,  er);
    chk({nm, " ena"},   ena,  e.ena);
    chk({nm, " dout"},  dout, e.dout);
    chk({nm, " done"},  done, e.done);
    @(posedge clk); #1;
    if (r) mq.delete();
    else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (er && v) begin
        for (int k = 7; k >= 0; k--) mq.push_back('{1'b1, d[k], 1'b0});
        for (int g = 0; g < NG; g++) mq.push_back('{1'b0, 1'b0, (g == NG - 1)});
      end
    end
  endtask

  initial begin
    logic [7:0]   a5;
    logic [127:0] word, rx;
    int           ena_cnt;
    a5 = 8'b1010_0101;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) tbl[2+k] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a5[7-k], 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; dv = 1'b0; din = '0;
    rst2 = 1'b1; dv2 = 1'b0; din2 = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; dv = tbl[i].dv; din = tbl[i].din;
      #1;
      chk($sformatf("vec%0d ready", i), rdy,  tbl[i].rdy);
      chk($sformatf("vec%0d ena",   i), ena,  tbl[i].ena);
      chk($sformatf("vec%0d dout",  i), dout, tbl[i].dout);
      chk($sformatf("vec%0d done",  i), done, tbl[i].done);
      @(posedge clk); #1;
    end

    // din_valid held high: FF then 00, one IDLE cycle between words.
    mcyc(1'b0, 1'b1, 8'hFF, "hold");
    for (int i = 0; i < 22; i++) mcyc(1'b0, 1'b1, 8'h00, "hold");
    for (int i = 0; i < 12; i++) mcyc(1'b0, 1'b0, 8'h00, "drain");

    // din disturbed mid-word.
    mcyc(1'b0, 1'b1, 8'hC3, "c3");
    for (int i = 0; i < 12; i++) mcyc(1'b0, (i % 2 == 0), 8'h3C, "c3");

    // Reset in the 4th SHIFT cycle, then a fresh word.
    mcyc(1'b0, 1'b1, 8'h5A, "abort");
    for (int i = 0; i < 3; i++) mcyc(1'b0, 1'b0, 8'h00, "abort");
    mcyc(1'b1, 1'b0, 8'h00, "abort rst");
    mcyc(1'b0, 1'b1, 8'h81, "w81");
    for (int i = 0; i < 11; i++) mcyc(1'b0, 1'b0, 8'h00, "w81");

    for (int i = 0; i < 400; i++)
      mcyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), 8'($urandom), "rand");
    rst = 1'b0; dv = 1'b0;

    // 128-bit word, NGAP=3, deserialised back.
    word = {$urandom, $urandom, $urandom, $urandom};
    rst2 = 1'b0; dv2 = 1'b1; din2 = word;
    #1;
    chk("w128 ready at accept", rdy2, 1'b1);
    @(posedge clk); #1;
    dv2 = 1'b0; din2 = ~word;
    rx = '0; ena_cnt = 0;
    for (int c = 0; c < 132; c++) begin
      #1;
      chk($sformatf("w128 ena c%0d", c), ena2, (c < 128));
      if (ena2) begin
        ena_cnt++;
        rx = {rx[126:0], dout2};
      end
      if (c >= 127) begin
        chk($sformatf("w128 done c%0d", c), done2, (c == 130));
        chk($sformatf("w128 ready c%0d", c), rdy2, (c == 131));
      end
      @(posedge clk); #1;
    end
    chk("w128 ena count", ena_cnt, 128);
    chk("w128 loopback", rx, word);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
